soft_reset_initiator: RTL and testbench
=======================================

# soft_reset_initiator

Drives the active-low `aresetn` input of a clock/reset map and closes the loop on the interconnect reset that the map returns. A request starts a reset sequence:
- assert `aresetn_out` for a minimum pulse width;
- confirm the synchronized feedback reset went low, then release;
- confirm the feedback came back high;
- report `done`, or report `timeout` if a phase stalls.

It is the reset-source end of the reset map, placed in the control domain that owns soft-reset of a kernel slot.

## Interface
Parameters:
- `PULSE_CYCLES`, default 16: minimum number of cycles `aresetn_out` is held low. Must be ≥ 1.
- `SYNC_STAGES`, default 2: depth of the feedback synchronizer. Must be ≥ 2.
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles spent in each wait phase. Must be > `PULSE_CYCLES`.

Ports:
- `aclk`  in  1: the only clock.
- `areset`  in  1: reset, asynchronous and active-high.
- `req`  in  1: sequence request, sampled on the rising edge of `aclk`. Level or pulse are both accepted.
- `fb_aresetn`  in  1: interconnect reset returned by the reset map. Active-low, asynchronous to the FSM, synchronized internally.
- `aresetn_out`  out  1: active-low reset driven to the reset map.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: one-cycle pulse when a sequence completes.
- `timeout`  out  1: one-cycle pulse when a wait phase exceeds `TIMEOUT_CYCLES`.
- `err`  out  1: sticky timeout flag. Cleared when the next sequence is accepted.

## Operation
- `fb_s` is `fb_aresetn` after `SYNC_STAGES` flops. The synchronizer flops reset to 0, meaning "in reset".
- FSM states: ASSERT, RELEASE, DONE, IDLE.
- **Reset** (`areset` high): the FSM enters ASSERT and clears `cnt`, `pend` and `err`.
  - Outputs under reset: `aresetn_out`=0, `busy`=1, `done`=0, `timeout`=0, `err`=0.
  - Consequence: every power-on runs one full sequence.
- **ASSERT**: `aresetn_out`=0 and `cnt` increments every cycle.
  - Go to RELEASE once `cnt` ≥ `PULSE_CYCLES`-1 and `fb_s`=0 on the same cycle. Clear `cnt` on the transition.
  - If `cnt` reaches `TIMEOUT_CYCLES`-1 first, go to IDLE and pulse `timeout`.
- **RELEASE**: `aresetn_out`=1 and `cnt` increments every cycle.
  - Go to DONE on the first cycle `fb_s`=1.
  - If `cnt` reaches `TIMEOUT_CYCLES`-1 first, go to IDLE and pulse `timeout`.
- **DONE**: lasts one cycle. `done`=1 and `aresetn_out`=1.
  - If `pend`=1, clear `pend` and go to ASSERT.
  - Otherwise go to IDLE.
- **IDLE**: `aresetn_out`=1 and `busy`=0.
  - `req`=1 moves the FSM to ASSERT, clears `cnt` and clears `err`.
- **Timeout handling**:
  - `timeout` is registered with the transition into IDLE.
  - `err` is set on that same edge.
  - `pend` is cleared on timeout, so pending requests are dropped.
- **Requests while busy**: `req`=1 in any state other than IDLE sets `pend`. Multiple requests collapse into one pending sequence.
- **Counter width**: `cnt` is $clog2(TIMEOUT_CYCLES) bits. It saturates and never wraps.
- **Outputs**: `done` and `timeout` are mutually exclusive, and every output is registered.

## Timing
- `req` sampled high in IDLE at edge N: `aresetn_out` goes 0 and `busy` goes 1 after edge N.
- Low pulse width is at least `PULSE_CYCLES`. It is exactly `PULSE_CYCLES` when `fb_s` is already low by then.
  - Typical case: the feedback echoes `aresetn_out` with map latency L. The pulse is then max(`PULSE_CYCLES`, L+`SYNC_STAGES`+1) cycles.
- From release to `done`: L'+`SYNC_STAGES`+1 cycles, where L' is the map's release latency.
- The cycle after `done`, `busy` is 0 unless a request is pending.
- Asserting `areset` in the middle of a sequence immediately forces `aresetn_out`=0 and the ASSERT state, without waiting for a clock edge.
- Deasserting `areset` resumes ASSERT with `cnt`=0.

## Test plan
- **Power-on sequence.** Setup: default parameters, feedback model = `aresetn_out` delayed 3 cycles, hold `areset` then release.
  - Required: `aresetn_out` low for 16 cycles after release, then high.
  - Required: `done` pulses exactly once, 3+2+1 = 6 cycles after `aresetn_out` rises. `err`=0.
- **Slow feedback.** Setup: feedback delay of 30 cycles, `req` in IDLE.
  - Required: pulse width is 30+2+1 = 33 cycles, not 16. `done` follows.
- **Stuck feedback.** Setup: `fb_aresetn` tied to 1, `req` in IDLE.
  - Required: `timeout` pulses after 1024 cycles in ASSERT, then `err`=1, `busy`=0, `aresetn_out`=1.
  - Required: the next `req` clears `err`.
- **Coalesced requests.** Setup: three `req` pulses during RELEASE.
  - Required: exactly one `done` for the running sequence, then one further sequence starting the cycle after DONE, then a second `done`. No third sequence.
- **Reset mid-sequence.** Setup: assert `areset` asynchronously during RELEASE.
  - Required: `aresetn_out` falls before the next `aclk` edge, with no `done` and no `timeout`.
  - Required: after deassert, a complete 16-cycle sequence runs.
- **Minimum parameters.** Setup: `PULSE_CYCLES`=1, `SYNC_STAGES`=2, `TIMEOUT_CYCLES`=8, `fb_aresetn` tied to `aresetn_out`.
  - Required: pulse of 3 cycles, `done` 3 cycles after release.

Source files
------------

// File: rtl/soft_reset_initiator.sv
// Reset-source end of a clock/reset map: drives aresetn_out, then waits for the
// synchronized feedback reset to fall and rise again before reporting done/timeout.
module soft_reset_initiator #(
    parameter int PULSE_CYCLES   = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic aclk,
    input  logic areset,
    input  logic req,
    input  logic fb_aresetn,
    output logic aresetn_out,
    output logic busy,
    output logic done,
    output logic timeout,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_IDLE    = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fb_s;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   err_q, err_d;
    logic                   timeout_d;
    logic                   aresetn_q, busy_q, done_q, timeout_q;

    // Synchronizer flops clear to 0 so the feedback reads "in reset" until proven otherwise.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fb_aresetn};
        end
    end

    assign fb_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        pend_d    = pend_q;
        err_d     = err_q;
        timeout_d = 1'b0;

        if (state_q != ST_IDLE && req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q >= PULSE_LAST && !fb_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    pend_d    = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (fb_s) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    pend_d    = 1'b0;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (pend_q) begin
                    state_d = ST_ASSERT;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // A request seen during the DONE cycle lands in pend; honour it here.
                if (req || pend_q) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            aresetn_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            aresetn_q <= (state_d != ST_ASSERT);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            timeout_q <= timeout_d;
        end
    end

    assign aresetn_out = aresetn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign err         = err_q;

endmodule

// File: tb/tb_soft_reset_initiator.sv
// Directed and randomized-latency checks of soft_reset_initiator against a
// closed-form model of pulse width, release-to-done latency and timeout.
module tb_soft_reset_initiator;

    localparam int P  = 16;
    localparam int S  = 2;
    localparam int T  = 1024;

    logic aclk = 1'b0;
    logic areset;
    logic req = 1'b0;
    logic fb_aresetn;
    logic aresetn_out, busy, done, timeout, err;

    logic m_req = 1'b0;
    logic m_aresetn_out, m_busy, m_done, m_timeout, m_err;

    logic [63:0] fbdl = '0;
    int          fb_lat = 3;
    logic        fb_stuck = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int to_cnt   = 0;
    int fall_cnt = 0;
    logic prev_rn = 1'b0;

    soft_reset_initiator #(
        .PULSE_CYCLES(P), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .aclk(aclk), .areset(areset), .req(req), .fb_aresetn(fb_aresetn),
        .aresetn_out(aresetn_out), .busy(busy), .done(done),
        .timeout(timeout), .err(err)
    );

    soft_reset_initiator #(
        .PULSE_CYCLES(1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)
    ) dut_min (
        .aclk(aclk), .areset(areset), .req(m_req), .fb_aresetn(m_aresetn_out),
        .aresetn_out(m_aresetn_out), .busy(m_busy), .done(m_done),
        .timeout(m_timeout), .err(m_err)
    );

    always #5 aclk = ~aclk;

    // Reset map model: feedback echoes aresetn_out fb_lat cycles later.
    always @(posedge aclk) fbdl <= {fbdl[62:0], aresetn_out};

    always_comb begin
        if (fb_stuck)         fb_aresetn = 1'b1;
        else if (fb_lat == 0) fb_aresetn = aresetn_out;
        else                  fb_aresetn = fbdl[fb_lat-1];
    end

    always @(negedge aclk) begin
        if (done === 1'b1)    done_cnt++;
        if (timeout === 1'b1) to_cnt++;
        if (prev_rn === 1'b1 && aresetn_out === 1'b0) fall_cnt++;
        prev_rn = aresetn_out;
    end

    function automatic int exp_pulse(input int pc, input int lat);
        return (pc > lat + S + 1) ? pc : lat + S + 1;
    endfunction

    function automatic int exp_done(input int lat);
        return lat + S + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic pulse_req(input logic use_m);
        @(negedge aclk);
        if (use_m) m_req = 1'b1; else req = 1'b1;
        @(negedge aclk);
        req   = 1'b0;
        m_req = 1'b0;
    endtask

    // Starts at a negedge where the pulse is already low; counts low cycles,
    // then cycles from release until done.
    task automatic measure(input logic use_m, output int pw, output int dd);
        pw = 0;
        while (((use_m ? m_aresetn_out : aresetn_out) === 1'b0) && pw < 3000) begin
            pw++;
            @(negedge aclk);
        end
        dd = 0;
        while (((use_m ? m_done : done) !== 1'b1) && dd < 3000) begin
            dd++;
            @(negedge aclk);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pw, dd, lat, d0, t0, f0, k;

        areset = 1'b0;
        #1 areset = 1'b1;
        #2;
        check("rst_aresetn_out", aresetn_out, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err", err, 0);

        // Power-on sequence
        fb_lat = 3;
        ticks(3);
        @(negedge aclk);
        areset = 1'b0;
        measure(1'b0, pw, dd);
        check("por_pulse", pw, exp_pulse(P, 3));
        check("por_done_lat", dd, exp_done(3));
        ticks(5);
        check("por_done_count", done_cnt, 1);
        check("por_err", err, 0);
        check("por_busy", busy, 0);

        // Slow feedback
        ticks(64);
        fb_lat = 30;
        d0 = done_cnt;
        pulse_req(1'b0);
        measure(1'b0, pw, dd);
        check("slow_pulse", pw, exp_pulse(P, 30));
        check("slow_done_lat", dd, exp_done(30));
        ticks(2);
        check("slow_done_count", done_cnt - d0, 1);
        check("slow_busy", busy, 0);

        // Randomized map latency
        for (int i = 0; i < 6; i++) begin
            ticks(64);
            lat = $urandom_range(0, 40);
            fb_lat = lat;
            d0 = done_cnt;
            pulse_req(1'b0);
            measure(1'b0, pw, dd);
            check("rand_pulse", pw, exp_pulse(P, lat));
            check("rand_done_lat", dd, exp_done(lat));
            @(negedge aclk);
            check("rand_busy_after", busy, 0);
            ticks(2);
            check("rand_done_count", done_cnt - d0, 1);
        end

        // Stuck feedback -> timeout
        ticks(64);
        fb_lat = 3;
        fb_stuck = 1'b1;
        t0 = to_cnt;
        pulse_req(1'b0);
        pw = 0;
        while (timeout !== 1'b1 && pw < 3000) begin
            if (aresetn_out === 1'b0) pw++;
            @(negedge aclk);
        end
        check("stuck_assert_cycles", pw, T);
        check("stuck_timeout", timeout, 1);
        check("stuck_aresetn_out", aresetn_out, 1);
        check("stuck_busy", busy, 0);
        check("stuck_err", err, 1);
        check("stuck_done", done, 0);
        @(negedge aclk);
        check("stuck_timeout_pulse", timeout, 0);
        check("stuck_err_sticky", err, 1);
        check("stuck_to_count", to_cnt - t0, 1);
        fb_stuck = 1'b0;
        ticks(64);
        pulse_req(1'b0);
        check("stuck_err_cleared", err, 0);
        check("stuck_rerun_busy", busy, 1);
        measure(1'b0, pw, dd);
        check("stuck_rerun_pulse", pw, exp_pulse(P, 3));
        check("stuck_rerun_done_lat", dd, exp_done(3));

        // Coalesced requests during RELEASE
        ticks(64);
        d0 = done_cnt;
        f0 = fall_cnt;
        pulse_req(1'b0);
        pw = 0;
        while (aresetn_out === 1'b0 && pw < 3000) begin
            pw++;
            @(negedge aclk);
        end
        check("coal_pulse1", pw, exp_pulse(P, 3));
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            req = (k == 0 || k == 2 || k == 4);
            @(negedge aclk);
            k++;
        end
        req = 1'b0;
        check("coal_done_lat1", k, exp_done(3));
        @(negedge aclk);
        check("coal_restart_aresetn", aresetn_out, 0);
        check("coal_restart_busy", busy, 1);
        measure(1'b0, pw, dd);
        check("coal_pulse2", pw, exp_pulse(P, 3));
        check("coal_done_lat2", dd, exp_done(3));
        ticks(100);
        check("coal_done_count", done_cnt - d0, 2);
        check("coal_seq_count", fall_cnt - f0, 2);
        check("coal_idle_busy", busy, 0);

        // Asynchronous reset during RELEASE
        ticks(64);
        pulse_req(1'b0);
        pw = 0;
        while (aresetn_out === 1'b0 && pw < 3000) begin
            pw++;
            @(negedge aclk);
        end
        check("mid_pulse_before", pw, exp_pulse(P, 3));
        ticks(2);
        d0 = done_cnt;
        t0 = to_cnt;
        #2 areset = 1'b1;
        #1;
        check("mid_async_aresetn", aresetn_out, 0);
        check("mid_async_busy", busy, 1);
        ticks(3);
        check("mid_no_done", done_cnt - d0, 0);
        @(negedge aclk);
        areset = 1'b0;
        measure(1'b0, pw, dd);
        check("mid_pulse_after", pw, exp_pulse(P, 3));
        check("mid_done_lat", dd, exp_done(3));
        ticks(5);
        check("mid_done_count", done_cnt - d0, 1);
        check("mid_no_timeout", to_cnt - t0, 0);

        // Minimum parameters, feedback tied to aresetn_out
        ticks(20);
        pulse_req(1'b1);
        measure(1'b1, pw, dd);
        check("min_pulse", pw, exp_pulse(1, 0));
        check("min_done_lat", dd, exp_done(0));
        ticks(3);
        check("min_busy", m_busy, 0);
        check("min_err", m_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
